// File: rtl/aes_128_top.sv
// Iterative AES-128 forward cipher: one round per clock, on-the-fly key expansion.
// Captures data_in/key once after reset release; ciphertext appears on cryptokey
// 11 rising edges later and then holds until the next reset.
// Ports:
//   clk       - sole clock, rising edge
//   reset     - synchronous, active-high; clears all state and restarts the core
//   data_in   - 128-bit plaintext, byte 0 = bits [127:120], column-major state
//   key       - 128-bit cipher key, same byte ordering
//   cryptokey - 128-bit ciphertext, registered, same byte ordering
module aes_128_top (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] data_in,
   input  logic [127:0] key,
   output logic [127:0] cryptokey
);

   localparam int unsigned BLOCK_W    = 128;
   localparam int unsigned RND_W      = 4;
   localparam int unsigned LAST_ROUND = 10;

   typedef logic [7:0] sbox_t [256];

   localparam sbox_t SBOX = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   // Multiply by x in GF(2^8) modulo 0x11b.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte substitution is position-independent, so byte order inside the word does not matter.
   function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] s);
      logic [BLOCK_W-1:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
      return r;
   endfunction

   // Row r of column c takes the byte from column (c+r) mod 4; byte n = 4*col + row.
   function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
      logic [BLOCK_W-1:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
      return r;
   endfunction

   function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
      logic [BLOCK_W-1:0] r;
      logic [7:0] a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   function automatic logic [7:0] rcon(input logic [RND_W-1:0] n);
      case (n)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // One key-schedule step: g(w3) = SubWord(RotWord(w3)) ^ Rcon, then ripple XOR.
   function automatic logic [BLOCK_W-1:0] next_key(input logic [BLOCK_W-1:0] k,
                                                   input logic [RND_W-1:0]   n);
      logic [31:0] w0, w1, w2, w3, rot, t;
      w0  = k[127:96];
      w1  = k[95:64];
      w2  = k[63:32];
      w3  = k[31:0];
      rot = {w3[23:0], w3[31:24]};
      t   = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
            ^ {rcon(n), 24'h000000};
      w0  = w0 ^ t;
      w1  = w1 ^ w0;
      w2  = w2 ^ w1;
      w3  = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   logic [BLOCK_W-1:0] state, state_d;
   logic [BLOCK_W-1:0] round_key, round_key_d;
   logic [BLOCK_W-1:0] cryptokey_d;
   logic [RND_W-1:0]   rnd, rnd_d;
   logic               done, done_d;
   logic [BLOCK_W-1:0] rk_new;
   logic [BLOCK_W-1:0] shifted;

   // Next-state: load at rnd 0, one round per cycle for rnd 1..10, hold once done.
   always_comb begin
      state_d     = state;
      round_key_d = round_key;
      cryptokey_d = cryptokey;
      rnd_d       = rnd;
      done_d      = done;
      rk_new      = next_key(round_key, rnd);
      shifted     = shift_rows(sub_bytes(state));
      if (!done) begin
         if (rnd == '0) begin
            state_d     = data_in ^ key;
            round_key_d = key;
            rnd_d       = RND_W'(1);
         end else begin
            round_key_d = rk_new;
            rnd_d       = rnd + RND_W'(1);
            if (rnd == RND_W'(LAST_ROUND)) begin
               state_d     = shifted ^ rk_new;
               cryptokey_d = shifted ^ rk_new;
               done_d      = 1'b1;
            end else begin
               state_d = mix_columns(shifted) ^ rk_new;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= '0;
         round_key <= '0;
         cryptokey <= '0;
         rnd       <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_d;
         round_key <= round_key_d;
         cryptokey <= cryptokey_d;
         rnd       <= rnd_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_aes_128_top.sv
// Self-checking bench for aes_128_top: FIPS-197 vectors, exact latency,
// input-change immunity, mid-operation reset and back-to-back blocks.
module tb_aes_128_top;

   logic         clk;
   logic         reset;
   logic [127:0] data_in;
   logic [127:0] key;
   logic [127:0] cryptokey;

   int errors = 0;
   int checks = 0;
   logic [127:0] exp_q [$];

   localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_DATA = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_DATA  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] Z_CT    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   aes_128_top dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .key       (key),
      .cryptokey (cryptokey)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse reset for one edge, present inputs, release; next posedge is E1.
   // Called at a falling edge; returns at the falling edge just before E1.
   task automatic start_block(input logic [127:0] d, input logic [127:0] k,
                              input logic [127:0] expect_ct);
      reset   = 1'b1;
      data_in = d;
      key     = k;
      @(negedge clk);
      reset   = 1'b0;
      exp_q.push_back(expect_ct);
   endtask

   task automatic test_reset;
      logic [127:0] exp;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_in = {$urandom, $urandom, $urandom, $urandom};
         key     = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         exp = '0;
         checks++;
         if (cryptokey !== exp) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got %h expected %h", i, cryptokey, exp);
         end
      end
   endtask

   task automatic test_fips_c1;
      logic [127:0] exp;
      int first_edge;
      first_edge = 0;
      start_block(C1_DATA, C1_KEY, C1_CT);
      for (int e = 1; e <= 20; e++) begin
         @(negedge clk);
         if (first_edge == 0 && cryptokey !== 128'h0) first_edge = e;
      end
      exp = exp_q.pop_front();
      checks++;
      if (cryptokey !== exp) begin
         errors++;
         $display("FAIL c1_value: got %h expected %h", cryptokey, exp);
      end
      checks++;
      if (first_edge != 11) begin
         errors++;
         $display("FAIL c1_latency: got edge %0d expected edge 11", first_edge);
      end
   endtask

   task automatic test_fips_b;
      logic [127:0] exp;
      start_block(B_DATA, B_KEY, B_CT);
      repeat (10) @(negedge clk);
      checks++;
      if (cryptokey !== 128'h0) begin
         errors++;
         $display("FAIL b_zero_at_e10: got %h expected 0", cryptokey);
      end
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (cryptokey !== exp) begin
         errors++;
         $display("FAIL b_value_at_e11: got %h expected %h", cryptokey, exp);
      end
   endtask

   task automatic test_zero_hold;
      logic [127:0] exp;
      int bad;
      start_block(128'h0, 128'h0, Z_CT);
      repeat (11) @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (cryptokey !== exp) begin
         errors++;
         $display("FAIL zero_value: got %h expected %h", cryptokey, exp);
      end
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         data_in = {$urandom, $urandom, $urandom, $urandom};
         key     = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         checks++;
         if (cryptokey !== exp) begin
            errors++;
            if (bad < 3) $display("FAIL zero_hold[%0d]: got %h expected %h", i, cryptokey, exp);
            bad++;
         end
      end
   endtask

   task automatic test_input_change;
      logic [127:0] exp;
      start_block(C1_DATA, C1_KEY, C1_CT);
      repeat (2) @(negedge clk);
      data_in = '1;
      key     = '1;
      repeat (9) @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (cryptokey !== exp) begin
         errors++;
         $display("FAIL input_change: got %h expected %h", cryptokey, exp);
      end
   endtask

   task automatic test_reset_mid;
      logic [127:0] exp;
      reset   = 1'b1;
      data_in = C1_DATA;
      key     = C1_KEY;
      @(negedge clk);
      reset   = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (cryptokey !== 128'h0) begin
            errors++;
            $display("FAIL reset_mid_clear[%0d]: got %h expected 0", i, cryptokey);
         end
      end
      data_in = B_DATA;
      key     = B_KEY;
      reset   = 1'b0;
      exp_q.push_back(B_CT);
      repeat (10) @(negedge clk);
      checks++;
      if (cryptokey !== 128'h0) begin
         errors++;
         $display("FAIL reset_mid_e10: got %h expected 0", cryptokey);
      end
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (cryptokey !== exp) begin
         errors++;
         $display("FAIL reset_mid_e11: got %h expected %h", cryptokey, exp);
      end
   endtask

   task automatic test_back_to_back;
      logic [127:0] exp;
      start_block(128'h0, 128'h0, Z_CT);
      repeat (11) @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (cryptokey !== exp) begin
         errors++;
         $display("FAIL b2b_first: got %h expected %h", cryptokey, exp);
      end
      // Single reset cycle between blocks must clear the previous result.
      reset   = 1'b1;
      data_in = C1_DATA;
      key     = C1_KEY;
      @(negedge clk);
      checks++;
      if (cryptokey !== 128'h0) begin
         errors++;
         $display("FAIL b2b_clear: got %h expected 0", cryptokey);
      end
      reset = 1'b0;
      exp_q.push_back(C1_CT);
      repeat (11) @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (cryptokey !== exp) begin
         errors++;
         $display("FAIL b2b_second: got %h expected %h", cryptokey, exp);
      end
   endtask

   initial begin
      reset   = 1'b1;
      data_in = '0;
      key     = '0;
      @(negedge clk);
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_zero_hold();
      test_input_change();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
